isr_fetch_ctrl: RTL and testbench

- Sequences instruction fetch between the main program ROM and the ISR ROM of the halfword-addressable instruction memory.
- Owns the sel_ISR select: takes interrupt requests, saves the main-program resume PC, and redirects fetch into the ISR ROM.
- On ISR return, restores the saved PC and masks re-entry for a programmable hold-off.
- Sits between the interrupt source and the fetch stage, alongside the PC register.

---
 rtl/isr_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_isr_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/isr_fetch_ctrl.sv
// Interrupt fetch sequencer: steers instruction fetch between main ROM and ISR ROM.
// Optional macro ISR_PENDING_EN latches request edges that arrive while entry is blocked.
`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 16
`endif

module isr_fetch_ctrl #(
  parameter logic [`PC_ADDR_BITS-1:0] ISR_BASE       = '0,
  parameter int                       HOLDOFF_CYCLES = 2,
  parameter int                       HOLDOFF_W      = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     stall,
  input  logic                     int_en,
  input  logic                     int_req,
  input  logic                     mret,
  input  logic [`PC_ADDR_BITS-1:0] pc_resume,
  output logic                     sel_ISR,
  output logic                     redirect,
  output logic [`PC_ADDR_BITS-1:0] redirect_pc,
  output logic                     int_ack,
  output logic                     in_isr
);

  localparam logic [1:0] ST_MAIN   = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_ISR    = 2'd2;
  localparam logic [1:0] ST_RETURN = 2'd3;

  logic [1:0]               state;
  logic [`PC_ADDR_BITS-1:0] saved_pc;
  logic [HOLDOFF_W-1:0]     holdoff_cnt;
  logic                     ack_q;
  logic                     req_eff;
  logic                     take;

`ifdef ISR_PENDING_EN
  logic int_req_q;
  logic pending;

  // Edges seen while entry is impossible are remembered until acknowledged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      int_req_q <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_q <= int_req;
      if (ack_q)
        pending <= 1'b0;
      else if (int_req && !int_req_q && ((state != ST_MAIN) || (holdoff_cnt != '0)))
        pending <= 1'b1;
    end
  end

  assign req_eff = int_req | pending;
`else
  assign req_eff = int_req;
`endif

  always_comb begin
    take = 1'b0;
    if ((state == ST_MAIN) && int_en && req_eff && (holdoff_cnt == '0) && !stall)
      take = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_MAIN;
      saved_pc    <= '0;
      holdoff_cnt <= '0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= take;
      case (state)
        ST_MAIN: begin
          if (holdoff_cnt != '0)
            holdoff_cnt <= holdoff_cnt - 1'b1;
          if (take) begin
            saved_pc <= {pc_resume[`PC_ADDR_BITS-1:1], 1'b0};
            state    <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          if (!stall)
            state <= ST_ISR;
        end
        ST_ISR: begin
          if (mret && !stall)
            state <= ST_RETURN;
        end
        default: begin
          if (!stall) begin
            holdoff_cnt <= HOLDOFF_W'(HOLDOFF_CYCLES);
            state       <= ST_MAIN;
          end
        end
      endcase
    end
  end

  // Outputs decode only registered state so no input reaches an output combinationally.
  always_comb begin
    sel_ISR     = (state == ST_ENTER) || (state == ST_ISR);
    in_isr      = (state == ST_ENTER) || (state == ST_ISR);
    redirect    = (state == ST_ENTER) || (state == ST_RETURN);
    int_ack     = ack_q;
    redirect_pc = '0;
    if (state == ST_ENTER)
      redirect_pc = ISR_BASE;
    else if (state == ST_RETURN)
      redirect_pc = saved_pc;
  end

endmodule

// File: tb/tb_isr_fetch_ctrl.sv
// Self-checking bench for isr_fetch_ctrl: directed scenarios plus a random soak
// compared against a cycle-indexed behavioural model.
`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 16
`endif

module tb_isr_fetch_ctrl;

  localparam int PCW = `PC_ADDR_BITS;
  localparam logic [PCW-1:0] BASE = PCW'('h0200);
  localparam int HOLD = 2;

  logic           clk = 1'b0;
  logic           nrst;
  logic           stall, int_en, int_req, mret;
  logic [PCW-1:0] pc_resume;
  logic           sel_ISR, redirect, int_ack, in_isr;
  logic [PCW-1:0] redirect_pc;

  int compared   = 0;
  int mismatched = 0;

  // Model: handler phase, resume address, and the first cycle index at which entry is allowed again.
  int             m_phase;
  logic [PCW-1:0] m_saved;
  int             m_allow;
  bit             m_ack;
  bit             m_pend;
  bit             m_prev_req;
  int             cyc = 0;

  isr_fetch_ctrl #(.ISR_BASE(BASE), .HOLDOFF_CYCLES(HOLD), .HOLDOFF_W(4)) dut (
    .clk(clk), .nrst(nrst), .stall(stall), .int_en(int_en), .int_req(int_req),
    .mret(mret), .pc_resume(pc_resume), .sel_ISR(sel_ISR), .redirect(redirect),
    .redirect_pc(redirect_pc), .int_ack(int_ack), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_phase    = 0;
    m_saved    = '0;
    m_allow    = 0;
    m_ack      = 0;
    m_pend     = 0;
    m_prev_req = 0;
  endtask

  task automatic checkAll(input string tag);
    bit             inside_handler;
    bit             overriding;
    logic [PCW-1:0] exp_pc;
    inside_handler = (m_phase == 1) || (m_phase == 2);
    overriding     = (m_phase == 1) || (m_phase == 3);
    exp_pc = (m_phase == 1) ? BASE : (m_phase == 3) ? m_saved : '0;
    checkOutput({tag, ".sel_ISR"},     32'(sel_ISR),     32'(inside_handler));
    checkOutput({tag, ".in_isr"},      32'(in_isr),      32'(inside_handler));
    checkOutput({tag, ".redirect"},    32'(redirect),    32'(overriding));
    checkOutput({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(exp_pc));
    checkOutput({tag, ".int_ack"},     32'(int_ack),     32'(m_ack));
  endtask

  // Advance the model by one clock edge using the rules for each phase.
  task automatic modelEdge(input bit req, input bit en, input bit mr, input bit st, input logic [PCW-1:0] pc);
    bit blocked;
    bit want;
    bit took;
    bit next_pend;
    blocked = (m_phase != 0) || (cyc < m_allow);
    want    = req;
`ifdef ISR_PENDING_EN
    want = req || m_pend;
    if (m_ack)
      next_pend = 0;
    else if (req && !m_prev_req && blocked)
      next_pend = 1;
    else
      next_pend = m_pend;
`else
    next_pend = 0;
`endif
    took = 0;
    case (m_phase)
      0: if (en && want && (cyc >= m_allow) && !st) begin
           m_saved = pc & ~PCW'(1);
           m_phase = 1;
           took    = 1;
         end
      1: if (!st) m_phase = 2;
      2: if (mr && !st) m_phase = 3;
      default: if (!st) begin
           m_phase = 0;
           m_allow = cyc + 1 + HOLD;
         end
    endcase
    m_ack      = took;
    m_pend     = next_pend;
    m_prev_req = req;
    cyc++;
  endtask

  task automatic applyStimulus(input string tag, input bit req, input bit en, input bit mr,
                               input bit st, input logic [PCW-1:0] pc);
    int_req   = req;
    int_en    = en;
    mret      = mr;
    stall     = st;
    pc_resume = pc;
    @(posedge clk);
    modelEdge(req, en, mr, st, pc);
    #1;
    checkAll(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 1, 0, 0, pc_resume);
  endtask

  int acks;
  int waited;

  initial begin
    nrst = 0; stall = 0; int_en = 0; int_req = 0; mret = 0; pc_resume = '0;
    modelReset();
    #1;
    checkAll("reset");
    @(negedge clk);
    nrst = 1;
    idle("post_reset", 2);

    // Basic entry and return
    applyStimulus("basic_req", 1, 1, 0, 0, PCW'('h0124));
    checkOutput("basic_entry_pc", 32'(redirect_pc), 32'(BASE));
    checkOutput("basic_entry_ack", 32'(int_ack), 32'd1);
    idle("basic_isr", 10);
    applyStimulus("basic_mret", 0, 1, 1, 0, PCW'('h0124));
    checkOutput("basic_return_pc", 32'(redirect_pc), 32'h0124);
    checkOutput("basic_return_sel", 32'(sel_ISR), 32'd0);
    idle("basic_after", 4);

    // Resume address is forced halfword-aligned
    applyStimulus("align_req", 1, 1, 0, 0, PCW'('h0047));
    idle("align_isr", 3);
    applyStimulus("align_mret", 0, 1, 1, 0, '0);
    checkOutput("align_return_pc", 32'(redirect_pc), 32'h0046);
    idle("align_after", 4);

    // Stall holds ENTER and then RETURN
    acks = 0;
    applyStimulus("stall_req", 1, 1, 0, 0, PCW'('h0310));
    acks += int_ack;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall_enter", 0, 1, 0, 1, '0);
      acks += int_ack;
      checkOutput("stall_enter_redirect", 32'(redirect), 32'd1);
    end
    applyStimulus("stall_release", 0, 1, 0, 0, '0);
    checkOutput("stall_enter_acks", 32'(acks), 32'd1);
    checkOutput("stall_in_isr", 32'(in_isr & ~redirect), 32'd1);
    applyStimulus("stall_mret", 0, 1, 1, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus("stall_return", 0, 1, 1, 1, '0);
    checkOutput("stall_return_pc", 32'(redirect_pc), 32'h0310);
    idle("stall_after", 4);

    // Request held high through return: two blocked MAIN cycles, then the accepting cycle
    applyStimulus("hold_req", 1, 1, 0, 0, PCW'('h0400));
    applyStimulus("hold_isr", 1, 1, 0, 0, '0);
    applyStimulus("hold_mret", 1, 1, 1, 0, '0);
    waited = 0;
    do begin
      applyStimulus("hold_wait", 1, 1, 0, 0, PCW'('h0500));
      waited++;
    end while (!int_ack && waited < 20);
    checkOutput("hold_gap", 32'(waited), 32'(HOLD + 2));
    applyStimulus("hold_isr2", 0, 1, 0, 0, '0);
    applyStimulus("hold_mret2", 0, 1, 1, 0, '0);
    checkOutput("hold_return_pc", 32'(redirect_pc), 32'h0500);
    idle("hold_after", 4);

    // Masked requests and stray mret
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus("mask", 1, 0, 0, 0, '0);
      acks += int_ack;
    end
    checkOutput("mask_acks", 32'(acks), 32'd0);
    applyStimulus("mret_main", 0, 1, 1, 0, '0);
    checkOutput("mret_main_redirect", 32'(redirect), 32'd0);

    // Requests inside the ISR do not nest
    applyStimulus("nest_req", 1, 1, 0, 0, PCW'('h0600));
    acks = int_ack;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("nest_isr", 1, 1, 0, 0, '0);
      acks += int_ack;
    end
    checkOutput("nest_acks", 32'(acks), 32'd1);
    applyStimulus("nest_mret", 0, 1, 1, 0, '0);
    idle("nest_after", 5);

    // Asynchronous reset mid-ISR
    applyStimulus("rst_req", 1, 1, 0, 0, PCW'('h0700));
    idle("rst_isr", 2);
    #2 nrst = 0;
    modelReset();
    #1;
    checkAll("rst_async");
    @(negedge clk);
    nrst = 1;
    idle("rst_after", 3);

    // One-cycle pulse during ISR: re-entry only when the pending flag exists
    applyStimulus("pend_req", 1, 1, 0, 0, PCW'('h0800));
    idle("pend_isr", 2);
    applyStimulus("pend_pulse", 1, 1, 0, 0, '0);
    idle("pend_isr2", 2);
    applyStimulus("pend_mret", 0, 1, 1, 0, '0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("pend_after", 0, 1, 0, 0, '0);
      acks += int_ack;
    end
`ifdef ISR_PENDING_EN
    checkOutput("pend_reentry", 32'(acks), 32'd1);
    idle("pend_isr3", 2);
    applyStimulus("pend_mret2", 0, 1, 1, 0, '0);
`else
    checkOutput("pend_reentry", 32'(acks), 32'd0);
`endif
    idle("pend_tail", 4);

    // Random soak against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 3) == 0),
                    PCW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
